// File: rtl/ir_nec_pkg.sv
// Shared types and NEC timing windows for the IR receive front end.
// Window limits are in 10 us ticks and inclusive.
package ir_nec_pkg;

  localparam int unsigned FRAME_BITS  = 32;

  localparam int unsigned LEAD_MK_MIN   = 800;
  localparam int unsigned LEAD_MK_MAX   = 1000;
  localparam int unsigned LEAD_SP_MIN   = 400;
  localparam int unsigned LEAD_SP_MAX   = 500;
  localparam int unsigned REPEAT_SP_MIN = 200;
  localparam int unsigned REPEAT_SP_MAX = 250;
  localparam int unsigned BIT_MK_MIN    = 40;
  localparam int unsigned BIT_MK_MAX    = 72;
  localparam int unsigned ZERO_SP_MIN   = 40;
  localparam int unsigned ZERO_SP_MAX   = 72;
  localparam int unsigned ONE_SP_MIN    = 140;
  localparam int unsigned ONE_SP_MAX    = 200;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StCheck
  } nec_state_e;

  function automatic logic in_win(input logic [31:0] w, input int unsigned lo,
                                  input int unsigned hi);
    return (w >= lo) && (w <= hi);
  endfunction

  // Address and command bytes must each be followed by their complement.
  function automatic logic frame_ok(input logic [31:0] sr);
    return (sr[15:8] == ~sr[7:0]) && (sr[31:24] == ~sr[23:16]);
  endfunction

endpackage

// File: rtl/ir_nec_decoder_if.sv
// Raw IR input plus the decoded strobes and frame fields.
// The decoder side uses master; the receive state machine uses slave.
interface ir_nec_decoder_if;
  logic       ir_in;
  logic       read;
  logic       DONE;
  logic       ERROR;
  logic [7:0] address;
  logic [7:0] command;

  modport master (input ir_in, output read, DONE, ERROR, address, command);
  modport slave  (output ir_in, input read, DONE, ERROR, address, command);
endinterface

// File: rtl/ir_pulse_timer.sv
// Synchronises the IR line, detects edges and measures the time since the
// last edge in ticks, saturating at the counter maximum.
module ir_pulse_timer #(
  parameter int unsigned TICK_CYCLES = 500,
  parameter int unsigned WIDTH_W     = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ir_in,
  output logic               fall,
  output logic               rise,
  output logic [WIDTH_W-1:0] width
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);

  logic               sync1_q, sync2_q, prev_q;
  logic [PW-1:0]      presc_q;
  logic [WIDTH_W-1:0] width_q;
  logic               tick;

  assign tick  = (presc_q == PMAX);
  assign fall  = prev_q & ~sync2_q;
  assign rise  = ~prev_q & sync2_q;
  assign width = width_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      presc_q <= '0;
      width_q <= '0;
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (fall || rise) begin
        width_q <= '0;
      end else if (tick && (width_q != '1)) begin
        width_q <= width_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC frame decoder: leader/bit classification FSM, LSB-first shift register
// and complement check, producing read/DONE/ERROR strobes.
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 500,
  parameter int unsigned WIDTH_W     = 11
) (
  input  logic               clk,
  input  logic               reset,
  ir_nec_decoder_if.master   bus
);

  logic               fall, rise;
  logic [WIDTH_W-1:0] width;
  logic [31:0]        w;
  logic               is_zero, is_one;

  nec_state_e  state_q;
  logic [31:0] sr_q;
  logic [4:0]  bit_cnt_q;
  logic        read_q, done_q, error_q;
  logic [7:0]  addr_q, cmd_q;

  ir_pulse_timer #(
    .TICK_CYCLES(TICK_CYCLES),
    .WIDTH_W    (WIDTH_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .ir_in(bus.ir_in),
    .fall (fall),
    .rise (rise),
    .width(width)
  );

  assign w       = 32'(width);
  assign is_zero = in_win(w, ZERO_SP_MIN, ZERO_SP_MAX);
  assign is_one  = in_win(w, ONE_SP_MIN, ONE_SP_MAX);

  assign bus.read    = read_q;
  assign bus.DONE    = done_q;
  assign bus.ERROR   = error_q;
  assign bus.address = addr_q;
  assign bus.command = cmd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      read_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      addr_q    <= '0;
      cmd_q     <= '0;
    end else begin
      read_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fall) state_q <= StLeadMark;
        end
        StLeadMark: begin
          if (rise) begin
            state_q <= in_win(w, LEAD_MK_MIN, LEAD_MK_MAX) ? StLeadSpace : StIdle;
          end else if (w > LEAD_MK_MAX) begin
            state_q <= StIdle;
          end
        end
        StLeadSpace: begin
          // Repeat codes fall through to IDLE silently, like any other bad space.
          if (fall) begin
            if (in_win(w, LEAD_SP_MIN, LEAD_SP_MAX)) begin
              state_q   <= StBitMark;
              bit_cnt_q <= '0;
              read_q    <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end else if (w > LEAD_SP_MAX) begin
            state_q <= StIdle;
          end
        end
        StBitMark: begin
          if (rise && in_win(w, BIT_MK_MIN, BIT_MK_MAX)) begin
            state_q <= StBitSpace;
          end else if (rise || (w > BIT_MK_MAX)) begin
            state_q <= StIdle;
            error_q <= 1'b1;
          end
        end
        StBitSpace: begin
          if (fall && (is_zero || is_one)) begin
            sr_q <= {is_one, sr_q[31:1]};
            if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
              state_q <= StCheck;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= StBitMark;
            end
          end else if (fall || (w > ONE_SP_MAX)) begin
            state_q <= StIdle;
            error_q <= 1'b1;
          end
        end
        StCheck: begin
          if (frame_ok(sr_q)) begin
            addr_q <= sr_q[7:0];
            cmd_q  <= sr_q[23:16];
            done_q <= 1'b1;
          end else begin
            error_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder: good, corrupt, repeat, noise, timeout
// and mid-frame reset cases with hand-computed expectations.
module tb_ir_nec_decoder;
  import ir_nec_pkg::*;

  localparam int unsigned TICK = 4;
  localparam logic [31:0] GOOD1 = 32'hF708_FB04;
  localparam logic [31:0] BAD1  = 32'hF708_FA04;
  localparam logic [31:0] GOOD2 = 32'h5AA5_EF10;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_total = 0, n_bad = 0;
  int   n_read = 0, n_done = 0, n_err = 0, n_multi = 0;
  int   read_cyc = 0, err_cyc = 0, lead_fall_cyc = 0, rise_cyc = 0;

  ir_nec_decoder_if bus ();

  ir_nec_decoder #(
    .TICK_CYCLES(TICK),
    .WIDTH_W    (11)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.read)  begin n_read = n_read + 1; read_cyc = cyc; end
    if (bus.DONE)  n_done = n_done + 1;
    if (bus.ERROR) begin n_err = n_err + 1; err_cyc = cyc; end
    if (int'(bus.read) + int'(bus.DONE) + int'(bus.ERROR) > 1) n_multi = n_multi + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_read = 0;
    n_done = 0;
    n_err  = 0;
  endtask

  // Drive a level for a whole number of ticks; returns at posedge + 1.
  task automatic hold(input logic lvl, input int unsigned ticks);
    bus.ir_in = lvl;
    repeat (ticks * TICK) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [31:0] word, input int nbits);
    hold(1'b0, 802);
    hold(1'b1, 402);
    lead_fall_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 42);
      hold(1'b1, word[i] ? 142 : 42);
    end
  endtask

  // The trailing mark is the stop mark for a full frame, or the next bit's mark.
  task automatic send_frame(input logic [31:0] word, input int nbits, input int unsigned tail);
    send_head(word, nbits);
    hold(1'b0, 42);
    rise_cyc = cyc;
    hold(1'b1, tail);
  endtask

  initial begin
    reset     = 1'b0;
    bus.ir_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_read", bus.read, 0);
    check_eq("rst_done", bus.DONE, 0);
    check_eq("rst_err", bus.ERROR, 0);
    check_eq("rst_addr", bus.address, 0);
    check_eq("rst_cmd", bus.command, 0);
    check_eq("rst_state", 32'(dut.state_q), 32'(StIdle));
    reset = 1'b1;
    @(posedge clk);
    #1;

    clr_counts();
    send_frame(GOOD1, 32, 30);
    check_eq("g1_read", n_read, 1);
    check_eq("g1_lat", read_cyc - lead_fall_cyc, 3);
    check_eq("g1_done", n_done, 1);
    check_eq("g1_err", n_err, 0);
    check_eq("g1_addr", bus.address, 8'h04);
    check_eq("g1_cmd", bus.command, 8'h08);

    clr_counts();
    send_frame(BAD1, 32, 30);
    check_eq("bad_read", n_read, 1);
    check_eq("bad_done", n_done, 0);
    check_eq("bad_err", n_err, 1);
    check_eq("bad_addr", bus.address, 8'h04);
    check_eq("bad_cmd", bus.command, 8'h08);

    clr_counts();
    hold(1'b0, 900);
    hold(1'b1, 225);
    hold(1'b0, 56);
    hold(1'b1, 30);
    check_eq("rep_read", n_read, 0);
    check_eq("rep_done", n_done, 0);
    check_eq("rep_err", n_err, 0);
    check_eq("rep_state", 32'(dut.state_q), 32'(StIdle));

    // 201 ticks after the clear: ERROR lands 805..808 clk after the driven rise.
    clr_counts();
    send_frame(GOOD1, 10, 250);
    check_eq("tmo_read", n_read, 1);
    check_eq("tmo_err", n_err, 1);
    check_eq("tmo_done", n_done, 0);
    check_eq("tmo_when", (err_cyc - rise_cyc >= 805) && (err_cyc - rise_cyc <= 808), 1);

    clr_counts();
    send_head(GOOD1, 15);
    hold(1'b0, 20);
    reset = 1'b0;
    #1;
    check_eq("mid_read", bus.read, 0);
    check_eq("mid_done", bus.DONE, 0);
    check_eq("mid_err", bus.ERROR, 0);
    check_eq("mid_addr", bus.address, 0);
    check_eq("mid_cmd", bus.command, 0);
    check_eq("mid_state", 32'(dut.state_q), 32'(StIdle));
    bus.ir_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_nread", n_read, 1);
    check_eq("mid_nerr", n_err, 0);
    check_eq("mid_ndone", n_done, 0);

    clr_counts();
    hold(1'b0, 200);
    hold(1'b1, 50);
    check_eq("noise_read", n_read, 0);
    check_eq("noise_err", n_err, 0);
    send_frame(GOOD2, 32, 30);
    check_eq("g2_read", n_read, 1);
    check_eq("g2_lat", read_cyc - lead_fall_cyc, 3);
    check_eq("g2_done", n_done, 1);
    check_eq("g2_err", n_err, 0);
    check_eq("g2_addr", bus.address, 8'h10);
    check_eq("g2_cmd", bus.command, 8'hA5);

    check_eq("one_hot", n_multi, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_nec_decoder.md
Name: ir_nec_decoder

Overview:
- Front end of the IR receive path. Samples the raw demodulated IR line, measures mark and space widths, and decodes 32-bit NEC frames (address, ~address, command, ~command).
- Produces the `read`, `DONE` and `ERROR` strobes consumed directly by the receive state machine (IDLE/READ/END).
- Holds the decoded address and command for downstream logic.

Parameters:
- TICK_CYCLES, 500, clk cycles per 10 us timing tick (50 MHz clk); the bench uses 4.
- WIDTH_W, 11, width-counter bits in ticks; the counter saturates at 2^WIDTH_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- ir_in  in  1  raw IR receiver output, asynchronous; idle high, 0 = carrier present (mark)
- read  out  1  one-cycle pulse: valid leader (9 ms mark + 4.5 ms space) accepted, bit capture starting
- DONE  out  1  one-cycle pulse: 32 bits received and complement check passed
- ERROR  out  1  one-cycle pulse: frame aborted after `read`
- address  out  8  address of last good frame
- command  out  8  command of last good frame

Behaviour:
- Reset is asynchronous and active-low. Clock is clk.
- Reset values: read=0, DONE=0, ERROR=0, address=0, command=0, state=IDLE, shift register=0, bit_cnt=0, prescaler=0, width counter=0, synchronizer flops=1.
- Input conditioning:
  - ir_in passes through a 2-flop synchronizer, then a registered previous-sample.
  - fall = prev&~cur (mark start); rise = ~prev&cur (space start).
  - Edge-to-decision latency is 3 clk.
- Timing:
  - The prescaler is free-running and issues a tick every TICK_CYCLES clocks.
  - The width counter increments on tick and saturates.
  - On any edge, the counter value W is evaluated and the counter clears to 0 in the same cycle.
  - Measurement is quantised to ±1 tick; the windows below absorb this.
- Windows (ticks, inclusive):
  - LEAD_MK 800..1000
  - LEAD_SP 400..500
  - REPEAT_SP 200..250
  - BIT_MK 40..72
  - ZERO_SP 40..72
  - ONE_SP 140..200
- States and transitions:
  - IDLE: on fall -> LEAD_MARK (counter cleared). Rise is ignored.
  - LEAD_MARK:
    - rise with W in LEAD_MK -> LEAD_SPACE.
    - rise outside the window, or W>1000 -> IDLE. No strobe (noise).
  - LEAD_SPACE:
    - fall with W in LEAD_SP -> BIT_MARK, bit_cnt=0, `read` pulses.
    - W in REPEAT_SP (repeat code) -> IDLE, no strobe; repeats are not supported.
    - any other W, or W>500 -> IDLE, no strobe.
  - BIT_MARK:
    - rise with W in BIT_MK -> BIT_SPACE.
    - otherwise, or W>72 -> ERROR pulse, IDLE.
  - BIT_SPACE:
    - fall with W in ZERO_SP: shift in 0.
    - fall with W in ONE_SP: shift in 1.
    - Shift is LSB first: sr <= {bit, sr[31:1]}.
    - If bit_cnt==31 -> CHECK; else bit_cnt++ and -> BIT_MARK.
    - Bad W, or W>200 -> ERROR pulse, IDLE.
  - CHECK (1 cycle):
    - If sr[15:8]==~sr[7:0] and sr[31:24]==~sr[23:16]: address<=sr[7:0], command<=sr[23:16], DONE pulses.
    - Otherwise ERROR pulses and address/command are held.
    - Always -> IDLE.
- Timeouts are evaluated every cycle; an edge arriving in the same cycle as a timeout takes priority.
- The trailing stop mark begins on the fall that completes bit 31, while the FSM is in CHECK. It is absorbed by IDLE: its rise is ignored.
- Strobe rules:
  - At most one of read/DONE/ERROR is high per cycle.
  - Every `read` is followed by exactly one DONE or ERROR.
  - DONE/ERROR never occur without a preceding `read`.
- Reset mid-frame: immediate return to IDLE with all outputs 0. No ERROR is emitted.

Decomposition:
- Package ir_nec_pkg: state enum typedef, window constants (LEAD_MK_MIN/MAX, etc.), FRAME_BITS=32.
- Sub-module ir_pulse_timer: synchronizer, edge detect, prescaler and saturating width counter.
  - Outputs: fall, rise, width[WIDTH_W-1:0].
- The FSM, shift register and check logic live in ir_nec_decoder.

Test Plan:
- Good frame, address 0x04 / command 0x08 (bytes 04 FB 08 F7, LSB first) -> one `read` 3 clk after the leader-space fall. DONE after bit 31. address=0x04, command=0x08. No ERROR.
- Same frame with byte1=0xFA -> `read`, then ERROR from CHECK, no DONE. address/command keep their prior values (0x04/0x08).
- Repeat code (900-tick mark + 225-tick space + 56-tick mark) -> no strobes; FSM back in IDLE.
- 200-tick noise mark, then idle -> no strobes; a following good frame (addr 0x10, cmd 0xA5) decodes correctly.
- Line held high after 10 bits -> ERROR exactly once, on the first cycle W>200 in BIT_SPACE. No DONE.
- Reset asserted during bit 15 -> all outputs 0 immediately, no ERROR. A subsequent good frame yields DONE with the correct values.
